// File: rtl/rvga_debug_tracer_if.sv
// Decode debug bus field widths and the interface carrying one decoded-instruction record.
// Producer drives modport o; tracer and other observers use modport i.
package rvga_dbg_pkg;
  localparam int OPC_W   = 7;
  localparam int ITYPE_W = 3;
  localparam int BROP_W  = 3;
  localparam int LDOP_W  = 3;
  localparam int STROP_W = 2;
  localparam int ARTOP_W = 4;
  localparam int ENTRY_W = OPC_W + ITYPE_W + BROP_W + LDOP_W + STROP_W + ARTOP_W;
endpackage

interface rvga_debugbus_if;
  import rvga_dbg_pkg::*;
  logic [OPC_W-1:0]   opcode;
  logic [ITYPE_W-1:0] inst_type;
  logic [BROP_W-1:0]  brop;
  logic [LDOP_W-1:0]  ldop;
  logic [STROP_W-1:0] strop;
  logic [ARTOP_W-1:0] artop;

  modport i (input  opcode, inst_type, brop, ldop, strop, artop);
  modport o (output opcode, inst_type, brop, ldop, strop, artop);
endinterface

// File: rtl/rvga_debug_tracer.sv
// Decode trace FIFO with per-class counters; a push is visible at the head one cycle later.
// Full FIFO drops captures (sticky overflow + drop count) unless the head pops in the same cycle.
module rvga_debug_tracer
  import rvga_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rvga_debugbus_if.i               dbg,
  input  logic                     dbg_valid_i,
  input  logic                     freeze_i,
  input  logic                     clear_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [ENTRY_W-1:0]       trace_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         br_cnt_o,
  output logic [CNT_W-1:0]         ld_cnt_o,
  output logic [CNT_W-1:0]         st_cnt_o,
  output logic [CNT_W-1:0]         alu_cnt_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]      PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] entry;
  logic               full, pop, cap, push, drop;
  logic               is_br, is_ld, is_st, is_alu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign entry = {dbg.opcode, dbg.inst_type, dbg.brop, dbg.ldop, dbg.strop, dbg.artop};

  // Extra pointer MSB separates full from empty; wrap is plain binary rollover.
  assign count_o       = wr_ptr - rd_ptr;
  assign full          = (count_o == FULL_CNT);
  assign trace_valid_o = (count_o != '0);
  assign trace_data_o  = mem[rd_ptr[AW-1:0]];

  assign pop  = trace_valid_o & trace_ready_i;
  assign cap  = dbg_valid_i & ~freeze_i & ~clear_i;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign is_br  = (dbg.opcode == 7'b1100011);
  assign is_ld  = (dbg.opcode == 7'b0000011);
  assign is_st  = (dbg.opcode == 7'b0100011);
  assign is_alu = (dbg.opcode == 7'b0110011) || (dbg.opcode == 7'b0010011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      br_cnt_o   <= '0;
      ld_cnt_o   <= '0;
      st_cnt_o   <= '0;
      alu_cnt_o  <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      br_cnt_o   <= '0;
      ld_cnt_o   <= '0;
      st_cnt_o   <= '0;
      alu_cnt_o  <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // Class counters track every accepted capture, dropped or not.
      if (cap && is_br)  br_cnt_o  <= sat_inc(br_cnt_o);
      if (cap && is_ld)  ld_cnt_o  <= sat_inc(ld_cnt_o);
      if (cap && is_st)  st_cnt_o  <= sat_inc(st_cnt_o);
      if (cap && is_alu) alu_cnt_o <= sat_inc(alu_cnt_o);
      if (drop) begin
        drop_cnt_o <= sat_inc(drop_cnt_o);
        overflow_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rvga_debug_tracer.sv
// Directed bench for rvga_debug_tracer: capture, full/drop, full+pop, no-bypass, wrap, clear and reset.
module tb_rvga_debug_tracer;
  import rvga_dbg_pkg::*;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALR = 7'b0110011;
  localparam logic [6:0] OP_ALI = 7'b0010011;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               dbg_valid_i, freeze_i, clear_i, trace_ready_i;
  logic               trace_valid_o, overflow_o;
  logic [ENTRY_W-1:0] trace_data_o;
  logic [4:0]         count_o;
  logic [31:0]        br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o, drop_cnt_o;

  int n_chk = 0;
  int n_bad = 0;

  rvga_debugbus_if dbg_bus ();

  rvga_debug_tracer #(.DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .dbg(dbg_bus.i),
    .dbg_valid_i(dbg_valid_i), .freeze_i(freeze_i), .clear_i(clear_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .count_o(count_o),
    .br_cnt_o(br_cnt_o), .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o),
    .alu_cnt_o(alu_cnt_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] rec(input logic [6:0] opc, input logic [14:0] low);
    return {opc, low};
  endfunction

  task automatic set_in(input logic [ENTRY_W-1:0] e, input logic v);
    dbg_bus.opcode    = e[21:15];
    dbg_bus.inst_type = e[14:12];
    dbg_bus.brop      = e[11:9];
    dbg_bus.ldop      = e[8:6];
    dbg_bus.strop     = e[5:4];
    dbg_bus.artop     = e[3:0];
    dbg_valid_i       = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freeze_i = 1'b0; clear_i = 1'b0; trace_ready_i = 1'b0;
    set_in(rec(OP_BR, 15'h1234), 1'b1);
    repeat (3) step();
    n_chk++; if (trace_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", trace_valid_o); end
    n_chk++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_chk++; if (trace_data_o !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", trace_data_o); end
    n_chk++; if ({br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o, drop_cnt_o} !== '0) begin n_bad++; $display("FAIL rst_cnts: got %h want 0", {br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o, drop_cnt_o}); end
    n_chk++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow_o); end
    set_in('0, 1'b0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_capture();
    logic [ENTRY_W-1:0] r [3];
    r[0] = rec(OP_BR, 15'h0011); r[1] = rec(OP_LD, 15'h0122); r[2] = rec(OP_ST, 15'h0233);
    for (int i = 0; i < 3; i++) begin set_in(r[i], 1'b1); step(); end
    set_in('0, 1'b0);
    n_chk++; if (count_o !== 5'd3) begin n_bad++; $display("FAIL cap_count: got %0d want 3", count_o); end
    n_chk++; if (trace_data_o !== r[0]) begin n_bad++; $display("FAIL cap_head: got %h want %h", trace_data_o, r[0]); end
    n_chk++; if ({br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin n_bad++; $display("FAIL cap_cls: got %0d/%0d/%0d/%0d want 1/1/1/0", br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o); end
  endtask

  task automatic test_full();
    clear_i = 1'b1; step(); clear_i = 1'b0;
    n_chk++; if (count_o !== 5'd0 || br_cnt_o !== 32'd0) begin n_bad++; $display("FAIL clr1: got cnt=%0d br=%0d want 0/0", count_o, br_cnt_o); end
    for (int i = 0; i < 18; i++) begin set_in(rec(OP_BR, 15'(i)), 1'b1); step(); end
    set_in('0, 1'b0);
    n_chk++; if (count_o !== 5'd16) begin n_bad++; $display("FAIL full_count: got %0d want 16", count_o); end
    n_chk++; if (drop_cnt_o !== 32'd2) begin n_bad++; $display("FAIL full_drop: got %0d want 2", drop_cnt_o); end
    n_chk++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL full_ovf: got %b want 1", overflow_o); end
    n_chk++; if (br_cnt_o !== 32'd18) begin n_bad++; $display("FAIL full_br: got %0d want 18", br_cnt_o); end
    n_chk++; if (trace_data_o !== rec(OP_BR, 15'd0)) begin n_bad++; $display("FAIL full_head: got %h want %h", trace_data_o, rec(OP_BR, 15'd0)); end
  endtask

  task automatic test_full_pop();
    logic [ENTRY_W-1:0] r_new;
    r_new = rec(OP_ALR, 15'h7abc);
    set_in(r_new, 1'b1); trace_ready_i = 1'b1;
    step();
    set_in('0, 1'b0);
    n_chk++; if (count_o !== 5'd16) begin n_bad++; $display("FAIL fp_count: got %0d want 16", count_o); end
    n_chk++; if (drop_cnt_o !== 32'd2) begin n_bad++; $display("FAIL fp_drop: got %0d want 2", drop_cnt_o); end
    for (int k = 1; k < 16; k++) begin
      n_chk++; if (trace_data_o !== rec(OP_BR, 15'(k))) begin n_bad++; $display("FAIL fp_order%0d: got %h want %h", k, trace_data_o, rec(OP_BR, 15'(k))); end
      step();
    end
    n_chk++; if (trace_data_o !== r_new || trace_valid_o !== 1'b1) begin n_bad++; $display("FAIL fp_tail: got %h v=%b want %h v=1", trace_data_o, trace_valid_o, r_new); end
    step();
    trace_ready_i = 1'b0;
    n_chk++; if (count_o !== 5'd0 || trace_valid_o !== 1'b0) begin n_bad++; $display("FAIL fp_empty: got cnt=%0d v=%b want 0/0", count_o, trace_valid_o); end
  endtask

  task automatic test_no_bypass();
    logic [ENTRY_W-1:0] r;
    r = rec(OP_LD, 15'h0555);
    set_in(r, 1'b1); trace_ready_i = 1'b1;
    #1;
    n_chk++; if (trace_valid_o !== 1'b0) begin n_bad++; $display("FAIL nb_n: got %b want 0", trace_valid_o); end
    step();
    set_in('0, 1'b0);
    n_chk++; if (trace_valid_o !== 1'b1 || trace_data_o !== r || count_o !== 5'd1) begin n_bad++; $display("FAIL nb_n1: got v=%b d=%h c=%0d want 1/%h/1", trace_valid_o, trace_data_o, count_o, r); end
    step();
    trace_ready_i = 1'b0;
    n_chk++; if (trace_valid_o !== 1'b0 || count_o !== 5'd0) begin n_bad++; $display("FAIL nb_n2: got v=%b c=%0d want 0/0", trace_valid_o, count_o); end
  endtask

  task automatic test_wrap();
    logic [ENTRY_W-1:0] q[$];
    logic [ENTRY_W-1:0] r;
    logic c, rd, pm;
    for (int i = 0; i < 60; i++) begin
      c  = (i % 3 != 2);
      rd = (i % 2 == 0);
      r  = rec((i % 2 == 0) ? OP_ALR : OP_ALI, 15'(16'h100 + i));
      set_in(r, c); trace_ready_i = rd;
      pm = (q.size() != 0) && rd;
      if (pm) begin
        n_chk++; if (trace_data_o !== q[0]) begin n_bad++; $display("FAIL wrap_data%0d: got %h want %h", i, trace_data_o, q[0]); end
        void'(q.pop_front());
      end
      if (c && (q.size() < 16 || pm)) q.push_back(r);
      step();
      n_chk++; if (count_o !== 5'(q.size())) begin n_bad++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, count_o, q.size()); end
    end
    set_in('0, 1'b0); trace_ready_i = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      n_chk++; if (trace_data_o !== q[0]) begin n_bad++; $display("FAIL wrap_drain%0d: got %h want %h", i, trace_data_o, q[0]); end
      void'(q.pop_front());
      step();
    end
    trace_ready_i = 1'b0;
    n_chk++; if (trace_valid_o !== 1'b0) begin n_bad++; $display("FAIL wrap_end: got %b want 0", trace_valid_o); end
    n_chk++; if (alu_cnt_o !== 32'd41) begin n_bad++; $display("FAIL wrap_alu: got %0d want 41", alu_cnt_o); end
    n_chk++; if (drop_cnt_o !== 32'd2) begin n_bad++; $display("FAIL wrap_drop: got %0d want 2", drop_cnt_o); end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 2; i++) begin set_in(rec(OP_ST, 15'(i)), 1'b1); step(); end
    freeze_i = 1'b1; set_in(rec(OP_ST, 15'h0077), 1'b1); step(); freeze_i = 1'b0;
    n_chk++; if (count_o !== 5'd2 || st_cnt_o !== 32'd2) begin n_bad++; $display("FAIL frz: got c=%0d st=%0d want 2/2", count_o, st_cnt_o); end
    clear_i = 1'b1; trace_ready_i = 1'b1; set_in(rec(OP_BR, 15'h0099), 1'b1);
    step();
    clear_i = 1'b0; trace_ready_i = 1'b0; set_in('0, 1'b0);
    n_chk++; if (count_o !== 5'd0 || trace_valid_o !== 1'b0 || overflow_o !== 1'b0) begin n_bad++; $display("FAIL clr_state: got c=%0d v=%b o=%b want 0/0/0", count_o, trace_valid_o, overflow_o); end
    n_chk++; if ({br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o, drop_cnt_o} !== '0) begin n_bad++; $display("FAIL clr_cnts: got %0d/%0d/%0d/%0d/%0d want 0", br_cnt_o, ld_cnt_o, st_cnt_o, alu_cnt_o, drop_cnt_o); end
    for (int i = 0; i < 3; i++) begin set_in(rec(OP_ST, 15'(i + 8)), 1'b1); step(); end
    set_in('0, 1'b0); trace_ready_i = 1'b1;
    step();
    n_chk++; if (count_o !== 5'd2 || st_cnt_o !== 32'd3) begin n_bad++; $display("FAIL pre_rst: got c=%0d st=%0d want 2/3", count_o, st_cnt_o); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (trace_valid_o !== 1'b0 || count_o !== 5'd0 || trace_data_o !== '0) begin n_bad++; $display("FAIL arst: got v=%b c=%0d d=%h want 0/0/0", trace_valid_o, count_o, trace_data_o); end
    n_chk++; if (st_cnt_o !== 32'd0) begin n_bad++; $display("FAIL arst_cnt: got %0d want 0", st_cnt_o); end
    trace_ready_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_full();
    test_full_pop();
    test_no_bypass();
    test_wrap();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
